// File: rtl/vg_wr_precomp.sv
// Write-data precompensation for a WD1793: synchronizes the controller's write strobes and
// re-times each data pulse into an early, nominal or late slot with a fixed width and recovery.
module vg_wr_precomp #(
    parameter int DLY_NOM = 4,
    parameter int PCOMP   = 4,
    parameter int PW      = 6,
    parameter int REC     = 2
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       vg_wd,
    input  logic       vg_wg,
    input  logic       vg_tr43,
    input  logic       vg_sl,
    input  logic       vg_sr,
    output logic       wdat_n,
    output logic       wgate_n,
    output logic       busy,
    output logic       ovf,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DLY   = 2'd1,
        PULSE = 2'd2,
        RECV  = 2'd3
    } state_t;

    localparam logic [3:0] D_NOM   = 4'(DLY_NOM);
    localparam logic [3:0] D_EARLY = 4'(DLY_NOM - PCOMP);
    localparam logic [3:0] D_LATE  = 4'(DLY_NOM + PCOMP);
    localparam logic [3:0] PW_C    = 4'(PW);
    localparam logic [3:0] REC_C   = 4'(REC);

    logic [4:0] meta_q;
    logic [4:0] sync_q;
    logic [1:0] fill_q;
    logic       wd_s, wg_s, tr_s, sl_s, sr_s;
    logic       wd_prev_q, wg_prev_q, armed_q;
    logic       wd_edge, wg_rise;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, dly_sel;
    logic       ovf_set, ovf_d;

    always_ff @(posedge fclk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            meta_q <= {vg_wd, vg_wg, vg_tr43, vg_sl, vg_sr};
            sync_q <= meta_q;
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    assign {wd_s, wg_s, tr_s, sl_s, sr_s} = sync_q;

    // Edges are only armed once a genuine low has come through the filled synchronizer,
    // so a line already high when reset releases does not look like a fresh edge.
    always_ff @(posedge fclk) begin
        if (rst) begin
            wd_prev_q <= 1'b0;
            wg_prev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            wd_prev_q <= wd_s;
            wg_prev_q <= wg_s;
            armed_q   <= armed_q | (fill_q[1] & ~wd_s);
        end
    end

    assign wd_edge = wd_s & ~wd_prev_q & armed_q;
    assign wg_rise = wg_s & ~wg_prev_q;

    always_comb begin
        dly_sel = D_NOM;
        if (tr_s && sl_s && !sr_s) begin
            dly_sel = D_EARLY;
        end else if (tr_s && sr_s && !sl_s) begin
            dly_sel = D_LATE;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wd_edge) begin
                    if (dly_sel == 4'd0) begin
                        state_d = PULSE;
                        cnt_d   = PW_C;
                    end else begin
                        state_d = DLY;
                        cnt_d   = dly_sel;
                    end
                end
            end
            DLY: begin
                if (cnt_q == 4'd1) begin
                    state_d = PULSE;
                    cnt_d   = PW_C;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 4'd1) begin
                    state_d = RECV;
                    cnt_d   = REC_C;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECV: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Dropping the gate aborts whatever is in flight.
        if (!wg_s) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    // An edge seen outside IDLE (including the RECV exit cycle) is lost and flagged.
    assign ovf_set = wd_edge & wg_s & (state_q != IDLE);
    assign ovf_d   = ovf_set ? 1'b1 : (wg_rise ? 1'b0 : ovf);

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wdat_n  <= 1'b1;
            wgate_n <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdat_n  <= (state_d != PULSE);
            wgate_n <= ~wg_s;
            ovf     <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vg_wr_precomp.sv
// Self-checking bench for vg_wr_precomp: a negedge monitor pops expected pulse start/width
// from a scoreboard queue filled by the driver tasks; scenario tasks check the status outputs.
`timescale 1ns/1ps
module tb_vg_wr_precomp;
    localparam int DLY_NOM = 4;
    localparam int PCOMP   = 4;
    localparam int PW      = 6;
    localparam int REC     = 2;

    logic       fclk    = 1'b0;
    logic       rst     = 1'b1;
    logic       vg_wd   = 1'b0;
    logic       vg_wg   = 1'b0;
    logic       vg_tr43 = 1'b0;
    logic       vg_sl   = 1'b0;
    logic       vg_sr   = 1'b0;
    logic       wdat_n, wgate_n, busy, ovf;
    logic [1:0] dbg_state;

    int          checks    = 0;
    int          errors    = 0;
    int          pulse_cnt = 0;
    logic [31:0] pc        = 0;

    // Scoreboard: expected falling cycle and expected low width of each wdat_n pulse.
    logic [31:0] exp_q[$];
    logic [31:0] exp_w_q[$];
    logic        prev_wdat = 1'b1;
    logic        cur_valid = 1'b0;
    logic [31:0] fall_pc, cur_w, exp_s;

    vg_wr_precomp #(.DLY_NOM(DLY_NOM), .PCOMP(PCOMP), .PW(PW), .REC(REC)) dut (
        .fclk      (fclk),
        .rst       (rst),
        .vg_wd     (vg_wd),
        .vg_wg     (vg_wg),
        .vg_tr43   (vg_tr43),
        .vg_sl     (vg_sl),
        .vg_sr     (vg_sr),
        .wdat_n    (wdat_n),
        .wgate_n   (wgate_n),
        .busy      (busy),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #18 fclk = ~fclk;
    always @(posedge fclk) pc <= pc + 1;

    function automatic logic [31:0] exp_delay(input logic tr, input logic sl, input logic sr);
        if (tr && sl && !sr) return 32'(DLY_NOM - PCOMP);
        if (tr && sr && !sl) return 32'(DLY_NOM + PCOMP);
        return 32'(DLY_NOM);
    endfunction

    // Monitor
    always @(negedge fclk) begin
        if (prev_wdat === 1'b1 && wdat_n === 1'b0) begin
            pulse_cnt++;
            fall_pc = pc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                cur_valid = 1'b0;
                $display("FAIL pulse_unexpected: wdat_n fell at cycle %0d, none expected", pc);
            end else begin
                exp_s     = exp_q.pop_front();
                cur_w     = exp_w_q.pop_front();
                cur_valid = 1'b1;
                if (pc !== exp_s) begin
                    errors++;
                    $display("FAIL pulse_start: fell at cycle %0d, expected %0d", pc, exp_s);
                end
            end
        end
        if (prev_wdat === 1'b0 && wdat_n === 1'b1 && cur_valid) begin
            checks++;
            cur_valid = 1'b0;
            if ((pc - fall_pc) !== cur_w) begin
                errors++;
                $display("FAIL pulse_width: low %0d cycles, expected %0d", pc - fall_pc, cur_w);
            end
        end
        prev_wdat = wdat_n;
    end

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic pulse_wd(input int hi, input logic expect_pulse, input logic [31:0] w,
                            output logic [31:0] n);
        @(negedge fclk);
        vg_wd = 1'b1;
        n = pc;
        if (expect_pulse) begin
            exp_q.push_back(n + 32'd3 + exp_delay(vg_tr43, vg_sl, vg_sr));
            exp_w_q.push_back(w);
        end
        repeat (hi) @(negedge fclk);
        vg_wd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(5);
        checks += 4;
        if (wdat_n !== 1'b1) begin errors++; $display("FAIL reset_wdat_n: got %b, expected 1", wdat_n); end
        if (wgate_n !== 1'b1) begin errors++; $display("FAIL reset_wgate_n: got %b, expected 1", wgate_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
        rst = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_nominal();
        logic [31:0] n;
        int busy_cnt;
        @(negedge fclk);
        vg_wg = 1'b1;
        wait_cyc(2);
        checks++;
        if (wgate_n !== 1'b1) begin errors++; $display("FAIL wgate_latency_early: got %b, expected 1", wgate_n); end
        wait_cyc(1);
        checks++;
        if (wgate_n !== 1'b0) begin errors++; $display("FAIL wgate_latency: got %b, expected 0", wgate_n); end
        wait_cyc(3);
        @(negedge fclk);
        vg_wd = 1'b1;
        n = pc;
        exp_q.push_back(n + 32'd3 + 32'(DLY_NOM));
        exp_w_q.push_back(32'(PW));
        busy_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge fclk);
            if (i == 7) vg_wd = 1'b0;
            if (busy === 1'b1) busy_cnt++;
        end
        checks += 2;
        if (busy_cnt != 12) begin errors++; $display("FAIL nominal_busy_len: got %0d, expected 12", busy_cnt); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL nominal_ovf: got %b, expected 0", ovf); end
    endtask

    task automatic test_precomp();
        logic [2:0] tbl [5];
        logic [31:0] n;
        tbl[0] = 3'b110; tbl[1] = 3'b101; tbl[2] = 3'b111; tbl[3] = 3'b100; tbl[4] = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge fclk);
            {vg_tr43, vg_sl, vg_sr} = tbl[i];
            wait_cyc(4);
            pulse_wd(3, 1'b1, 32'(PW), n);
            wait_cyc(25);
            checks++;
            if (ovf !== 1'b0) begin errors++; $display("FAIL precomp_ovf[%0d]: got %b, expected 0", i, ovf); end
        end
        {vg_tr43, vg_sl, vg_sr} = 3'b000;
        wait_cyc(4);
    endtask

    task automatic clear_ovf_check(input string tag);
        vg_wg = 1'b0;
        wait_cyc(4);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL %s_ovf_hold: got %b, expected 1", tag, ovf); end
        vg_wg = 1'b1;
        wait_cyc(4);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL %s_ovf_clear: got %b, expected 0", tag, ovf); end
    endtask

    task automatic test_overrun();
        logic [31:0] n, m;
        pulse_wd(3, 1'b1, 32'(PW), n);
        wait_cyc(4);
        pulse_wd(3, 1'b0, 32'(PW), m);
        wait_cyc(15);
        checks += 2;
        if (ovf !== 1'b1) begin errors++; $display("FAIL overrun_ovf: got %b, expected 1", ovf); end
        if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy: got %b, expected 0", busy); end
        clear_ovf_check("overrun");
    endtask

    task automatic test_recv_boundary();
        logic [31:0] n, m;
        pulse_wd(3, 1'b1, 32'(PW), n);
        wait_cyc(8);
        pulse_wd(3, 1'b0, 32'(PW), m);
        wait_cyc(25);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL recv_exit_ovf: got %b, expected 1", ovf); end
        clear_ovf_check("recv_exit");
        pulse_wd(3, 1'b1, 32'(PW), n);
        wait_cyc(9);
        pulse_wd(3, 1'b1, 32'(PW), m);
        wait_cyc(25);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL after_recv_ovf: got %b, expected 0", ovf); end
    endtask

    task automatic test_wg_drop();
        logic [31:0] n;
        pulse_wd(3, 1'b1, 32'd4, n);
        wait_cyc(5);
        vg_wg = 1'b0;
        wait_cyc(2);
        checks += 2;
        if (wgate_n !== 1'b0) begin errors++; $display("FAIL wg_drop_wgate_early: got %b, expected 0", wgate_n); end
        if (wdat_n !== 1'b0) begin errors++; $display("FAIL wg_drop_wdat_early: got %b, expected 0", wdat_n); end
        wait_cyc(1);
        checks += 3;
        if (wdat_n !== 1'b1) begin errors++; $display("FAIL wg_drop_wdat: got %b, expected 1", wdat_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL wg_drop_busy: got %b, expected 0", busy); end
        if (wgate_n !== 1'b1) begin errors++; $display("FAIL wg_drop_wgate: got %b, expected 1", wgate_n); end
        // Edge with the gate low must be ignored and not flag overrun.
        wait_cyc(3);
        pulse_wd(3, 1'b0, 32'(PW), n);
        wait_cyc(20);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL wg_low_edge_ovf: got %b, expected 0", ovf); end
        vg_wg = 1'b1;
        wait_cyc(6);
    endtask

    task automatic test_reset_mid_dly();
        logic [31:0] n;
        int busy_cnt;
        @(negedge fclk);
        vg_wd = 1'b1;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(1);
        checks += 4;
        if (wdat_n !== 1'b1) begin errors++; $display("FAIL rst_dly_wdat_n: got %b, expected 1", wdat_n); end
        if (wgate_n !== 1'b1) begin errors++; $display("FAIL rst_dly_wgate_n: got %b, expected 1", wgate_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_dly_busy: got %b, expected 0", busy); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_dly_ovf: got %b, expected 0", ovf); end
        wait_cyc(2);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fclk);
            if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 0) begin errors++; $display("FAIL rst_stale_edge: busy %0d cycles, expected 0", busy_cnt); end
        vg_wd = 1'b0;
        wait_cyc(3);
        pulse_wd(3, 1'b1, 32'(PW), n);
        wait_cyc(25);
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] n;
        pulse_wd(3, 1'b1, 32'd2, n);
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(1);
        checks++;
        if (wdat_n !== 1'b1) begin errors++; $display("FAIL rst_pulse_wdat_n: got %b, expected 1", wdat_n); end
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_back_to_back();
        logic [31:0] n;
        int start_cnt;
        @(negedge fclk);
        vg_tr43 = 1'b1;
        wait_cyc(4);
        start_cnt = pulse_cnt;
        for (int i = 0; i < 100; i++) begin
            vg_sl = 1'($urandom_range(0, 1));
            vg_sr = 1'($urandom_range(0, 1));
            wait_cyc(3);
            pulse_wd(3, 1'b1, 32'(PW), n);
            wait_cyc(21);
        end
        wait_cyc(10);
        checks += 2;
        if (pulse_cnt - start_cnt != 100) begin
            errors++;
            $display("FAIL train_count: got %0d pulses, expected 100", pulse_cnt - start_cnt);
        end
        if (ovf !== 1'b0) begin errors++; $display("FAIL train_ovf: got %b, expected 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_precomp();
        test_overrun();
        test_recv_boundary();
        test_wg_drop();
        test_reset_mid_dly();
        test_reset_mid_pulse();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulses_missing: %0d expected pulses never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vg_wr_precomp.md
VG_WR_PRECOMP -- requirements
Module: vg_wr_precomp

Interface
REQ-001 Parameter DLY_NOM, default 4: nominal pulse delay in fclk cycles; range 0..15.
REQ-002 Parameter PCOMP, default 4: precompensation shift in fclk cycles; must satisfy PCOMP <= DLY_NOM and DLY_NOM+PCOMP <= 15.
REQ-003 Parameter PW, default 6: write pulse width in fclk cycles; range 1..15.
REQ-004 Parameter REC, default 2: minimum high recovery time after each pulse, in fclk cycles; range 1..15.
REQ-005 fclk  in  1  single clock, nominally 28 MHz; all logic is clocked on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 vg_wd  in  1  write data pulses from the WD1793; active-high; asynchronous.
REQ-008 vg_wg  in  1  write gate from the WD1793; active-high; asynchronous.
REQ-009 vg_tr43  in  1  track > 43 indication; enables precompensation; asynchronous.
REQ-010 vg_sl, vg_sr  in  1 each  early (SL) and late (SR) precompensation requests; asynchronous.
REQ-011 wdat_n  out  1  floppy write data; active-low; registered.
REQ-012 wgate_n  out  1  floppy write gate; active-low; registered.
REQ-013 busy  out  1  high in every FSM state except IDLE.
REQ-014 ovf  out  1  sticky overrun flag.

Function
REQ-015 vg_wd, vg_wg, vg_tr43, vg_sl and vg_sr shall each pass through a 2-FF synchronizer; the synchronized values are wd_s, wg_s, tr_s, sl_s and sr_s.
REQ-016 wgate_n shall equal the inverse of wg_s, registered once more: total latency from vg_wg to wgate_n is 3 clocks.
REQ-017 An edge event E shall be the cycle in which wd_s = 1 and its previous-cycle value = 0.
REQ-018 The delay d shall be selected from tr_s, sl_s and sr_s sampled in cycle E:
- tr_s = 0, or sl_s = sr_s: d = DLY_NOM.
- sl_s = 1 and sr_s = 0: d = DLY_NOM - PCOMP (early).
- sr_s = 1 and sl_s = 0: d = DLY_NOM + PCOMP (late).
REQ-019 The FSM states shall be IDLE, DLY, PULSE and RECV.
REQ-020 IDLE: on E with wg_s = 1, go to DLY with counter = d if d > 0; go directly to PULSE if d = 0.
REQ-021 DLY: the counter decrements each cycle; on reaching 1, go to PULSE.
REQ-022 wdat_n shall be low exactly in cycles E+d+1 through E+d+PW.
REQ-023 PULSE: after PW cycles, go to RECV. RECV: wdat_n is high; after REC cycles, go to IDLE.
REQ-024 An E occurring in DLY, PULSE or RECV shall be discarded and shall set ovf; the in-progress pulse shall be unaffected.
REQ-025 An E occurring in the same cycle that RECV exits to IDLE shall count as overrun (discarded, ovf set).
REQ-026 wg_s = 0 shall force IDLE and wdat_n = 1 on the next clock, truncating any pulse in progress; E with wg_s = 0 shall be ignored and shall not set ovf.
REQ-027 ovf shall clear on the rising edge of wg_s; if an overrun occurs in the same cycle, the set shall win.
REQ-028 Counters shall be 4 bits wide; d shall never wrap, as guaranteed by the REQ-002 constraints.

Reset
REQ-029 While rst = 1, the block shall hold: wdat_n = 1, wgate_n = 1, busy = 0, ovf = 0, FSM in IDLE, counters 0, all synchronizer and edge registers 0.
REQ-030 rst asserted mid-pulse shall force wdat_n = 1 on the next clock.
REQ-031 After rst deasserts, a vg_wd line already high shall not produce an E until it goes low and then high again.

Verification
REQ-032 wg = 1, tr43 = 0, single vg_wd pulse of 7 clocks -> wdat_n low for 6 clocks, starting 5 clocks after E; busy high for 12 clocks.
REQ-033 tr43 = 1, sl = 1 -> wdat_n falls at E+1; tr43 = 1, sr = 1 -> wdat_n falls at E+9; tr43 = 1, sl = sr = 1 -> wdat_n falls at E+5.
REQ-034 Two vg_wd edges 8 clocks apart -> exactly one wdat_n pulse and ovf = 1; a following wg 0->1 transition clears ovf.
REQ-035 wg dropped 2 clocks into the PULSE state -> wdat_n returns high on the next clock, busy = 0, wgate_n = 1 three clocks after the vg_wg fall.
REQ-036 rst asserted during DLY with vg_wd held high -> all outputs at reset values; no pulse after rst release until a fresh vg_wd rising edge.
REQ-037 Train of 100 edges spaced 28 clocks with random sl/sr, tr43 = 1 -> 100 pulses, each with delay 0, 4 or 8 per REQ-018; ovf stays 0.
